// File: rtl/pwm_mch_if.sv
//----------------------------------------------------------------------
// pwm_mch_if : register-bus bundle shared by the PWM blocks.
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

interface pwm_mch_if;
    logic        reg_cs;
    logic        reg_wr;
    logic [3:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic [3:0]  reg_be;
    logic [31:0] reg_rdata;
    logic        reg_ack;

    modport master (
        output reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_cs, reg_wr, reg_addr, reg_wdata, reg_be,
        output reg_rdata, reg_ack
    );
endinterface

`default_nettype wire

// File: rtl/pwm_mch.sv
//----------------------------------------------------------------------
// pwm_mch : multi-channel PWM, shared prescaler/counter, double-buffered
//           compares and per-channel complementary dead-time outputs.
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module pwm_mch #(
    parameter int NCH = 4,
    parameter int CW  = 16,
    parameter int DTW = 8
) (
    input  wire             mclk,
    input  wire             h_reset_n,
    pwm_mch_if.slave        bus,
    output logic [NCH-1:0]  pwm_h,
    output logic [NCH-1:0]  pwm_l,
    output logic            pwm_ovflow,
    output logic            pwm_os_done
);

    localparam logic [3:0] c_ADDR_CTRL   = 4'd0;
    localparam logic [3:0] c_ADDR_PERIOD = 4'd1;
    localparam logic [3:0] c_ADDR_STATUS = 4'd2;
    localparam int         c_ADDR_COMP0  = 3;

    logic            r_ack;
    logic [31:0]     r_rdata;
    logic            r_enb;
    logic            r_oneshot;
    logic            r_dupdate;
    logic [3:0]      r_scale;
    logic [DTW-1:0]  r_dt;
    logic [CW-1:0]   r_period;
    logic [CW-1:0]   r_period_sh;
    logic [CW-1:0]   r_comp [NCH];
    logic [NCH-1:0]  r_inv;
    logic            r_os_done;
    logic            r_ovf_sticky;
    logic            r_ovf;
    logic [14:0]     r_pre;
    logic [CW-1:0]   r_cnt;

    logic            w_acc;
    logic            w_wr;
    logic [31:0]     w_mask;
    logic [31:0]     w_rd_img;
    logic [31:0]     w_wr_val;
    logic            w_unused;
    logic            w_os_clr;
    logic            w_ovf_w1c;
    logic [14:0]     w_pmask;
    logic            w_tick;
    logic            w_active;
    logic            w_rollover;
    logic            w_load_sh;

    assign w_acc  = bus.reg_cs & ~r_ack;
    assign w_wr   = w_acc & bus.reg_wr;
    assign w_mask = {{8{bus.reg_be[3]}}, {8{bus.reg_be[2]}},
                     {8{bus.reg_be[1]}}, {8{bus.reg_be[0]}}};

    always_comb begin
        w_rd_img = '0;
        case (bus.reg_addr)
            c_ADDR_CTRL: begin
                w_rd_img[0]       = r_enb;
                w_rd_img[1]       = r_oneshot;
                w_rd_img[2]       = r_dupdate;
                w_rd_img[7:4]     = r_scale;
                w_rd_img[8 +: DTW] = r_dt;
            end
            c_ADDR_PERIOD: w_rd_img[CW-1:0] = r_period;
            c_ADDR_STATUS: begin
                w_rd_img[31]     = r_ovf_sticky;
                w_rd_img[30]     = r_os_done;
                w_rd_img[CW-1:0] = r_cnt;
            end
            default: begin
                for (int n = 0; n < NCH; n++) begin
                    if (bus.reg_addr == 4'(c_ADDR_COMP0 + n)) begin
                        w_rd_img[31]     = r_inv[n];
                        w_rd_img[CW-1:0] = r_comp[n];
                    end
                end
            end
        endcase
    end

    // Byte-enable merge against the current contents of the addressed register.
    assign w_wr_val  = (w_rd_img & ~w_mask) | (bus.reg_wdata & w_mask);
    assign w_unused  = ^w_wr_val;
    assign w_os_clr  = w_wr && (bus.reg_addr == c_ADDR_CTRL) && (!w_wr_val[0] || !w_wr_val[1]);
    assign w_ovf_w1c = w_wr && (bus.reg_addr == c_ADDR_STATUS) && bus.reg_be[3] && bus.reg_wdata[31];

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            r_ack        <= 1'b0;
            r_rdata      <= '0;
            r_enb        <= 1'b0;
            r_oneshot    <= 1'b0;
            r_dupdate    <= 1'b0;
            r_scale      <= '0;
            r_dt         <= '0;
            r_period     <= '0;
            r_inv        <= '0;
            r_os_done    <= 1'b0;
            r_ovf_sticky <= 1'b0;
            for (int n = 0; n < NCH; n++) r_comp[n] <= '0;
        end else begin
            r_ack   <= w_acc;
            r_rdata <= (w_acc && !bus.reg_wr) ? w_rd_img : '0;
            if (w_wr && bus.reg_addr == c_ADDR_CTRL) begin
                r_enb     <= w_wr_val[0];
                r_oneshot <= w_wr_val[1];
                r_dupdate <= w_wr_val[2];
                r_scale   <= w_wr_val[7:4];
                r_dt      <= w_wr_val[8 +: DTW];
            end
            if (w_wr && bus.reg_addr == c_ADDR_PERIOD) r_period <= w_wr_val[CW-1:0];
            for (int n = 0; n < NCH; n++) begin
                if (w_wr && bus.reg_addr == 4'(c_ADDR_COMP0 + n)) begin
                    r_comp[n] <= w_wr_val[CW-1:0];
                    r_inv[n]  <= w_wr_val[31];
                end
            end
            if (w_os_clr)                    r_os_done <= 1'b0;
            else if (w_rollover && r_oneshot) r_os_done <= 1'b1;
            if (w_rollover)     r_ovf_sticky <= 1'b1;
            else if (w_ovf_w1c) r_ovf_sticky <= 1'b0;
        end
    end

    // Tick when the low `scale` bits of the free-running prescaler are all ones.
    assign w_pmask    = ~(15'h7FFF << r_scale);
    assign w_tick     = r_enb && ((r_pre & w_pmask) == w_pmask);
    assign w_active   = r_enb && !r_os_done;
    assign w_rollover = w_active && w_tick && (r_cnt == r_period_sh);
    // Shadows track the programmed values while disabled, so enabling starts fresh.
    assign w_load_sh  = !r_enb || (w_rollover && !r_dupdate);

    always_ff @(posedge mclk or negedge h_reset_n) begin
        if (!h_reset_n) begin
            r_pre       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_period_sh <= '0;
        end else begin
            r_pre <= r_enb ? r_pre + 15'd1 : '0;
            r_ovf <= w_rollover;
            if (!w_active)  r_cnt <= '0;
            else if (w_tick) r_cnt <= (r_cnt == r_period_sh) ? '0 : r_cnt + CW'(1);
            if (w_load_sh)  r_period_sh <= r_period;
        end
    end

    generate
        for (genvar n = 0; n < NCH; n++) begin : g_ch
            logic [CW-1:0]  r_comp_sh;
            logic           r_inv_sh;
            logic           r_rawq;
            logic           r_h;
            logic           r_l;
            logic [DTW-1:0] r_dtc;
            logic [DTW-1:0] w_dtc_nxt;
            logic           w_raw;
            logic           w_edge;

            assign w_raw     = w_active && ((r_cnt < r_comp_sh) ^ r_inv_sh);
            assign w_edge    = w_raw ^ r_rawq;
            // Any raw edge (re)starts the dead band; outputs only drive once it expires.
            assign w_dtc_nxt = w_edge ? r_dt : ((r_dtc != '0) ? r_dtc - DTW'(1) : '0);

            always_ff @(posedge mclk or negedge h_reset_n) begin
                if (!h_reset_n) begin
                    r_comp_sh <= '0;
                    r_inv_sh  <= 1'b0;
                    r_rawq    <= 1'b0;
                    r_dtc     <= '0;
                    r_h       <= 1'b0;
                    r_l       <= 1'b0;
                end else begin
                    if (w_load_sh) begin
                        r_comp_sh <= r_comp[n];
                        r_inv_sh  <= r_inv[n];
                    end
                    if (!w_active) begin
                        r_rawq <= 1'b0;
                        r_dtc  <= '0;
                        r_h    <= 1'b0;
                        r_l    <= 1'b0;
                    end else begin
                        r_rawq <= w_raw;
                        r_dtc  <= w_dtc_nxt;
                        r_h    <= w_raw && (w_dtc_nxt == '0);
                        r_l    <= !w_raw && (w_dtc_nxt == '0);
                    end
                end
            end

            assign pwm_h[n] = r_h;
            assign pwm_l[n] = r_l;
        end
    endgenerate

    assign bus.reg_ack   = r_ack;
    assign bus.reg_rdata = r_rdata;
    assign pwm_ovflow    = r_ovf;
    assign pwm_os_done   = r_os_done;

endmodule

`default_nettype wire

// File: tb/tb_pwm_mch.sv
//----------------------------------------------------------------------
// tb_pwm_mch : directed self-checking bench for pwm_mch.
// Rev 1.0
//----------------------------------------------------------------------
`default_nettype none

module tb_pwm_mch;
    localparam int NCH = 4;
    localparam int CW  = 16;
    localparam int DTW = 8;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NCH-1:0] pwm_h;
    logic [NCH-1:0] pwm_l;
    logic           pwm_ovflow;
    logic           pwm_os_done;

    pwm_mch_if bif ();

    pwm_mch #(.NCH(NCH), .CW(CW), .DTW(DTW)) dut (
        .mclk        (clk),
        .h_reset_n   (rst_n),
        .bus         (bif),
        .pwm_h       (pwm_h),
        .pwm_l       (pwm_l),
        .pwm_ovflow  (pwm_ovflow),
        .pwm_os_done (pwm_os_done)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_overlap = 0;
    logic [31:0] sb_q[$];

    always @(negedge clk) if ((pwm_h & pwm_l) != '0) n_overlap++;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input logic [31:0] e);
        sb_q.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $error("FAIL %s: observed %h expected <scoreboard empty>", tag, obs);
        end else begin
            cmp(tag, obs, sb_q.pop_front());
        end
    endtask

    task automatic bus_xfer(input logic wr, input logic [3:0] a, input logic [31:0] d,
                            input logic [3:0] be, output logic [31:0] rd);
        @(negedge clk);
        bif.reg_cs = 1'b1; bif.reg_wr = wr; bif.reg_addr = a;
        bif.reg_wdata = d; bif.reg_be = be;
        @(negedge clk);
        cmp("ack_rise", {31'd0, bif.reg_ack}, 32'd1);
        rd = bif.reg_rdata;
        bif.reg_cs = 1'b0; bif.reg_wr = 1'b0;
        @(negedge clk);
        cmp("ack_fall", {31'd0, bif.reg_ack}, 32'd0);
    endtask

    task automatic wr_reg(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
        logic [31:0] rd;
        bus_xfer(1'b1, a, d, be, rd);
    endtask

    task automatic rd_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [31:0] rd;
        expect_val(exp);
        bus_xfer(1'b0, a, 32'd0, 4'h0, rd);
        chk(tag, rd);
    endtask

    task automatic sync_ovf(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            if (pwm_ovflow) ok = 1'b1;
        end
    endtask

    task automatic count10(input int ch, output int hc, output int lc, output int oc);
        hc = 0; lc = 0; oc = 0;
        repeat (10) begin
            @(negedge clk);
            hc += int'(pwm_h[ch]);
            lc += int'(pwm_l[ch]);
            oc += int'(pwm_ovflow);
        end
    endtask

    // One full period (scale 0, period 9) beginning right after a rollover pulse.
    task automatic measure(input string tag, input int ch, input int eh, input int el);
        logic ok;
        int   hc, lc, oc;
        expect_val(32'd1); expect_val(32'(eh)); expect_val(32'(el)); expect_val(32'd1);
        sync_ovf(ok);
        count10(ch, hc, lc, oc);
        chk({tag, "_sync"}, {31'd0, ok});
        chk({tag, "_h"}, 32'(hc));
        chk({tag, "_l"}, 32'(lc));
        chk({tag, "_ovf"}, 32'(oc));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic ok;
        int   h1, l1, o1, h2, l2, o2;
        int   oh0, ol0, oh1, oovf;

        bif.reg_cs = 1'b0; bif.reg_wr = 1'b0; bif.reg_addr = '0;
        bif.reg_wdata = '0; bif.reg_be = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        cmp("rst_h", {28'd0, pwm_h}, 32'd0);
        cmp("rst_l", {28'd0, pwm_l}, 32'd0);
        cmp("rst_ovf", {31'd0, pwm_ovflow}, 32'd0);
        cmp("rst_osd", {31'd0, pwm_os_done}, 32'd0);
        rd_reg("rst_ctrl", 4'd0, 32'd0);
        rd_reg("rst_period", 4'd1, 32'd0);
        rd_reg("rst_status", 4'd2, 32'd0);
        for (int i = 0; i < NCH; i++) rd_reg("rst_comp", 4'(3 + i), 32'd0);
        rd_reg("unmapped", 4'd15, 32'd0);

        wr_reg(4'd1, 32'h1234_5678, 4'b0010);
        rd_reg("be_period", 4'd1, 32'h0000_5600);

        wr_reg(4'd1, 32'd9, 4'hF);
        wr_reg(4'd3, 32'd3, 4'hF);
        wr_reg(4'd0, 32'h0000_0001, 4'hF);
        rd_reg("ctrl_en", 4'd0, 32'h0000_0001);
        repeat (12) @(negedge clk);
        measure("dt0", 0, 3, 7);
        measure("dt0_ch1", 1, 0, 10);

        wr_reg(4'd0, 32'h0000_0201, 4'hF);
        rd_reg("ctrl_dt", 4'd0, 32'h0000_0201);
        repeat (12) @(negedge clk);
        measure("dt2", 0, 1, 5);
        cmp("overlap_dt2", 32'(n_overlap), 32'd0);

        wr_reg(4'd0, 32'h0000_0001, 4'hF);
        repeat (12) @(negedge clk);
        sync_ovf(ok);
        cmp("mid_sync", {31'd0, ok}, 32'd1);
        expect_val(32'd3); expect_val(32'd7);
        fork
            begin
                count10(0, h1, l1, o1);
                count10(0, h2, l2, o2);
            end
            wr_reg(4'd3, 32'd7, 4'hF);
        join
        chk("mid_old_duty", 32'(h1));
        chk("mid_new_duty", 32'(h2));

        wr_reg(4'd0, 32'h0000_0005, 4'hF);
        wr_reg(4'd3, 32'd3, 4'hF);
        repeat (12) @(negedge clk);
        measure("dup_hold", 0, 7, 3);
        wr_reg(4'd0, 32'h0000_0001, 4'hF);
        repeat (12) @(negedge clk);
        measure("dup_rel", 0, 3, 7);

        wr_reg(4'd3, 32'd0, 4'hF);
        wr_reg(4'd4, 32'd20, 4'hF);
        repeat (12) @(negedge clk);
        measure("comp0_zero", 0, 0, 10);
        measure("comp1_full", 1, 10, 0);
        wr_reg(4'd3, 32'h8000_0003, 4'hF);
        rd_reg("comp0_inv_rd", 4'd3, 32'h8000_0003);
        repeat (12) @(negedge clk);
        measure("inv", 0, 7, 3);

        wr_reg(4'd0, 32'h0000_0000, 4'hF);
        cmp("dis_h", {28'd0, pwm_h}, 32'd0);
        cmp("dis_l", {28'd0, pwm_l}, 32'd0);
        wr_reg(4'd1, 32'd4, 4'hF);
        wr_reg(4'd3, 32'd3, 4'hF);
        expect_val(32'd6); expect_val(32'd4); expect_val(32'd10); expect_val(32'd1);
        oh0 = 0; ol0 = 0; oh1 = 0; oovf = 0;
        fork
            repeat (50) begin
                @(negedge clk);
                oh0  += int'(pwm_h[0]);
                ol0  += int'(pwm_l[0]);
                oh1  += int'(pwm_h[1]);
                oovf += int'(pwm_ovflow);
            end
            wr_reg(4'd0, 32'h0000_0013, 4'hF);
        join
        chk("os_h0", 32'(oh0));
        chk("os_l0", 32'(ol0));
        chk("os_h1", 32'(oh1));
        chk("os_ovf", 32'(oovf));
        cmp("os_done", {31'd0, pwm_os_done}, 32'd1);
        cmp("os_h_idle", {28'd0, pwm_h}, 32'd0);
        cmp("os_l_idle", {28'd0, pwm_l}, 32'd0);
        rd_reg("os_status", 4'd2, 32'hC000_0000);
        wr_reg(4'd2, 32'h8000_0000, 4'hF);
        rd_reg("w1c_status", 4'd2, 32'h4000_0000);
        wr_reg(4'd0, 32'h0000_0002, 4'hF);
        cmp("os_clr", {31'd0, pwm_os_done}, 32'd0);
        rd_reg("os_clr_status", 4'd2, 32'h0000_0000);

        wr_reg(4'd1, 32'd9, 4'hF);
        wr_reg(4'd0, 32'h0000_0001, 4'hF);
        repeat (12) @(negedge clk);
        cmp("pre_rst_h1", {31'd0, pwm_h[1]}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        cmp("arst_h", {28'd0, pwm_h}, 32'd0);
        cmp("arst_l", {28'd0, pwm_l}, 32'd0);
        cmp("arst_ovf", {31'd0, pwm_ovflow}, 32'd0);
        #4 rst_n = 1'b1;
        rd_reg("arst_ctrl", 4'd0, 32'd0);
        rd_reg("arst_period", 4'd1, 32'd0);
        rd_reg("arst_comp1", 4'd4, 32'd0);

        cmp("overlap_total", 32'(n_overlap), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/pwm_mch.md
Name: pwm_mch

Overview:
Multi-channel, parametrised PWM generator. NCH channels share one prescaler and one period counter of width CW; each channel has its own compare value. Each channel drives a complementary output pair with programmable dead-time. Compare and period registers are double-buffered and load on rollover, giving glitch-free updates. Sits on the same reg-bus as the existing PWM blocks and drives pads through the GPIO mux.

Parameters:
NCH, 4, number of channels (1..12)
CW, 16, period/compare/counter width (8..24)
DTW, 8, dead-time counter width

Ports:
mclk  in  1  system clock
h_reset_n  in  1  asynchronous active-low reset
reg_cs  in  1  register chip select
reg_wr  in  1  1=write, 0=read
reg_addr  in  4  word address
reg_wdata  in  32  write data
reg_be  in  4  byte enables
reg_rdata  out  32  read data, valid with reg_ack
reg_ack  out  1  one-cycle access acknowledge
pwm_h  out  NCH  high-side outputs
pwm_l  out  NCH  low-side (complementary) outputs
pwm_ovflow  out  1  one-mclk pulse at each period rollover
pwm_os_done  out  1  level; one-shot completed

Behaviour:
- Clock and reset: single clock mclk; reset h_reset_n is asynchronous, active-low. Reset clears all registers, counters and shadows to 0; all outputs 0.
- Reg access: reg_ack pulses on the cycle after reg_cs is sampled high with reg_ack low; one access per two cycles minimum. Writes honour reg_be. Reads return registered data with reg_ack; unmapped addresses read 0.
- Register map:
  - 0 CTRL: [0] enb, [1] oneshot, [2] dupdate (block shadow load), [7:4] scale, [8+DTW-1:8] dead-time DT (mclk cycles).
  - 1 PERIOD: [CW-1:0].
  - 2 STATUS: [CW-1:0] live counter; [30] os_done, read-only; [31] ovflow_sticky, write-1-to-clear.
  - 3..3+NCH-1 COMPn: [CW-1:0] compare; [31] inv for channel n.
- Prescaler: tick asserts for one mclk every 2^scale cycles; scale=0 gives a tick every cycle. The prescaler clears while enb=0.
- Counter: advances on tick. At tick with cnt==period_sh, cnt goes to 0 and pwm_ovflow pulses on the next cycle. On that same rollover, period_sh/comp_sh/inv_sh load from the programmed registers unless dupdate=1.
- Shadows also load on enb 0->1, so the first period uses current values.
- Raw channel output: raw_n = (cnt < comp_sh_n) XOR inv_sh_n.
  - comp=0 gives 0% duty.
  - comp > period gives 100% duty.
  - period=0 gives cnt stuck at 0, with ovflow every tick.
- Dead-time, per channel: each edge of raw_n loads that channel's DTW counter with DT; both pwm_h and pwm_l are 0 while the counter is nonzero.
  - When the counter reaches 0, pwm_h=raw_n and pwm_l=~raw_n.
  - An edge arriving during the dead band reloads the counter, so no overlap is ever possible.
  - DT=0: outputs follow raw with one register stage.
  - Invariant: pwm_h & pwm_l == 0 in every cycle.
- Disable: enb=0 forces cnt=0 and raw=0. pwm_h=0; pwm_l=0 (no dead band on disable).
- One-shot:
  - At the first rollover with oneshot=1, the counter holds at 0 and outputs go to 0.
  - pwm_os_done sets; pwm_ovflow still pulses once.
  - os_done clears when enb is written 0 or oneshot is written 0.
- Simultaneous events:
  - Register write and rollover in the same cycle: the shadow loads the OLD value, and the new value applies next period.
  - Sticky-clear and ovflow in the same cycle: set wins.
- Reset mid-operation: asserting h_reset_n low immediately forces all outputs low, regardless of clock.

Test Plan:
- Reset, then read all registers -> all 0; pwm_h=pwm_l=0; reg_ack pulses 1 cycle after cs.
- period=9, comp0=3, scale=0, DT=0, enb=1 -> pwm_h[0] high 3 of every 10 mclk; pwm_ovflow pulses every 10 cycles; pwm_l[0] is the complement.
- Same config with DT=2 -> both outputs low for 2 cycles after each raw edge; pwm_h high 1 cycle per period; pwm_h & pwm_l never 1.
- Write comp0=7 mid-period -> the current period keeps duty 3, the next period has duty 7. With dupdate=1 -> duty stays 3 until dupdate=0 and the next rollover.
- comp0=0 -> pwm_h stuck 0; comp1=20 with period=9 -> pwm_h[1] stuck 1; inv=1 on comp0=3 -> high 7 of 10.
- oneshot=1, period=4, scale=1 -> exactly one 10-mclk period, then pwm_os_done=1 and STATUS[30]=1; writing enb=0 clears it; h_reset_n pulse mid-period -> outputs 0 asynchronously.
